// File: rtl/piezo_tone_decoder.sv
// Receive-side tone classifier: measures square-wave half-periods and locks
// onto one of eight scale notes after CONFIRM consecutive matching halves.
module piezo_tone_decoder #(
  parameter int TOL     = 48,
  parameter int CONFIRM = 4,
  parameter int TIMEOUT = 8191,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             note_valid,
  output logic [2:0]       note_idx,
  output logic [7:0]       note_onehot,
  output logic             note_strobe,
  output logic [CNT_W-1:0] half_len
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_CONF = 2'd2;
  localparam logic [1:0] S_LOCK = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [3:0]       CONF_V  = 4'(CONFIRM);

  function automatic int nominal(input int k);
    case (k)
      0:       return 3822;
      1:       return 3405;
      2:       return 3034;
      3:       return 2863;
      4:       return 2551;
      5:       return 2273;
      6:       return 2025;
      default: return 1911;
    endcase
  endfunction

  logic             sync1_q, sync2_q, prev_q;
  logic             tone_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [3:0]       mcnt_inc;
  logic             hit;
  logic [2:0]       hit_idx;
  logic             lock_d;
  logic             note_valid_q, note_valid_d;
  logic [2:0]       note_idx_q, note_idx_d;
  logic [7:0]       note_onehot_q, note_onehot_d;
  logic             note_strobe_q, note_strobe_d;
  logic [CNT_W-1:0] half_len_q, half_len_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tone_edge = sync2_q ^ prev_q;

  // Counter value at an edge is the half-period; it restarts at 1 so that
  // a wave toggling every N cycles reads back exactly N.
  always_comb begin
    cnt_d = cnt_q;
    if (tone_edge)
      cnt_d = CNT_W'(1);
    else if (cnt_q < CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // A saturated counter never matches, even if TIMEOUT sits near a nominal.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      int diff;
      diff = int'(cnt_q) - nominal(k);
      if (diff < 0) diff = -diff;
      if (cnt_q != CNT_MAX && diff <= TOL) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  assign mcnt_inc = mcnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    mcnt_d  = mcnt_q;
    if (tone_edge) begin
      case (state_q)
        S_IDLE: state_d = S_MEAS;
        S_MEAS: begin
          if (hit) begin
            cand_d  = hit_idx;
            mcnt_d  = 4'd1;
            state_d = (CONF_V == 4'd1) ? S_LOCK : S_CONF;
          end
        end
        S_CONF: begin
          if (!hit) begin
            state_d = S_MEAS;
            mcnt_d  = 4'd0;
          end else if (hit_idx == cand_q) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc >= CONF_V) state_d = S_LOCK;
          end else begin
            cand_d = hit_idx;
            mcnt_d = 4'd1;
            if (CONF_V == 4'd1) state_d = S_LOCK;
          end
        end
        default: begin
          // A different note always costs the lock, even with CONFIRM==1.
          if (!hit) begin
            state_d = S_MEAS;
            mcnt_d  = 4'd0;
          end else if (hit_idx != cand_q) begin
            state_d = S_CONF;
            cand_d  = hit_idx;
            mcnt_d  = 4'd1;
          end
        end
      endcase
    end else if (cnt_q == CNT_MAX && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cand_d  = 3'd0;
      mcnt_d  = 4'd0;
    end
  end

  always_comb begin
    lock_d        = (state_d == S_LOCK);
    note_valid_d  = lock_d;
    note_idx_d    = lock_d ? cand_d : 3'd0;
    note_onehot_d = lock_d ? (8'b1 << cand_d) : 8'h00;
    note_strobe_d = lock_d && (state_q != S_LOCK);
    half_len_d    = half_len_q;
    if (tone_edge && state_q != S_IDLE)
      half_len_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      state_q       <= S_IDLE;
      cand_q        <= 3'd0;
      mcnt_q        <= 4'd0;
      note_valid_q  <= 1'b0;
      note_idx_q    <= 3'd0;
      note_onehot_q <= 8'h00;
      note_strobe_q <= 1'b0;
      half_len_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      mcnt_q        <= mcnt_d;
      note_valid_q  <= note_valid_d;
      note_idx_q    <= note_idx_d;
      note_onehot_q <= note_onehot_d;
      note_strobe_q <= note_strobe_d;
      half_len_q    <= half_len_d;
    end
  end

  assign note_valid  = note_valid_q;
  assign note_idx    = note_idx_q;
  assign note_onehot = note_onehot_q;
  assign note_strobe = note_strobe_q;
  assign half_len    = half_len_q;

endmodule
